// File: rtl/arith_pkg.sv
// Shared definitions for the datapath arithmetic unit (multiplier and divider).
//   arith_state_e : three-state sequencing used by both iterative units
//   ARITH_WIDTH   : default operand width
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    localparam int unsigned ARITH_WIDTH = 4;

endpackage

// File: rtl/mul_datapath.sv
// Shift-and-add multiplier datapath: accumulator, multiplicand (left shift),
// multiplier (right shift) and the conditional adder.
// Optional MUL_SIGNED_EN: operands are two's complement; their magnitudes are
// multiplied and the sign is applied when the result is written.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture a/b, clear accumulator
//   step       perform one add/shift iteration
//   finish     last iteration: write final accumulator into result
//   a, b       operands (WIDTH bits)
//   result     product (2*WIDTH bits), held between finishes
module mul_datapath
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] final_val;
    logic [WIDTH-1:0]   a_in, b_in;

`ifdef MUL_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W = 1;
    localparam logic [2*WIDTH-1:0] ONE_P = 1;
    logic sign_q, sign_d;

    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
    // still correct when read as unsigned.
    assign a_in      = a[WIDTH-1] ? (~a + ONE_W) : a;
    assign b_in      = b[WIDTH-1] ? (~b + ONE_W) : b;
    assign final_val = sign_q ? (~acc_sum + ONE_P) : acc_sum;
`else
    assign a_in      = a;
    assign b_in      = b;
    assign final_val = acc_sum;
`endif

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef MUL_SIGNED_EN
        sign_d   = sign_q;
`endif
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_in};
            mplier_d = b_in;
            acc_d    = '0;
`ifdef MUL_SIGNED_EN
            sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (finish) begin
                result_d = final_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MUL_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef MUL_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign result = result_q;

endmodule

// File: rtl/shift_add_multiply.sv
// Sequential shift-and-add multiplier with start/done handshake.
// Product of two WIDTH-bit operands after WIDTH cycles; one op per WIDTH+1
// cycles, back-to-back accept allowed from the DONE state.
// Optional macro MUL_SIGNED_EN selects two's-complement operands.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request; sampled only in IDLE or DONE
//   A, B    multiplicand / multiplier, captured on the accepting edge
//   busy    high while iterating
//   done    one-cycle pulse, result valid
//   result  2*WIDTH-bit product, held until the next completion
module shift_add_multiply
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned      CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE = 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    arith_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load, step, finish;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step    = 1'b1;
                count_d = count_q + CNT_ONE;
                // Final iteration: the datapath writes the result on this edge.
                if (count_q == LAST) begin
                    finish  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mul_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .finish (finish),
        .a      (A),
        .b      (B),
        .result (result)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_add_multiply.sv
module tb_shift_add_multiply;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A, B;
    logic           busy, done;
    logic [2*W-1:0] result;

    int unsigned    n_vec = 0;
    int unsigned    n_bad = 0;
    logic [2*W-1:0] last_res;

    always #5 clk = ~clk;

    shift_add_multiply #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int          sa, sb;
        logic [31:0] p;
        sa = int'(a);
        sb = int'(b);
`ifdef MUL_SIGNED_EN
        if (a[W-1]) sa = sa - (1 << W);
        if (b[W-1]) sb = sb - (1 << W);
`endif
        p = 32'(sa * sb);
        return p[2*W-1:0];
    endfunction

    // Issue one operation and follow it through to its done pulse.
    // When hold is set, start stays high and A/B are scrambled during BUSY.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string tag, input bit hold);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check({tag, " busy@accept"}, 32'(busy), 32'd1);
        check({tag, " done@accept"}, 32'(done), 32'd0);
        check({tag, " res_held@accept"}, 32'(result), 32'(last_res));
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            if (hold) begin
                start = 1'b1;
                A = W'($urandom);
                B = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            check({tag, " res_held"}, 32'(result), 32'(last_res));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " result"}, 32'(result), 32'(exp));
        last_res = exp;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, " idle_done"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_res"}, 32'(result), 32'(last_res));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int unsigned  gap;
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        last_res = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle("post_reset");

        run_op(4'd5, 4'd3, 8'd15, "5x3", 1'b0);
        idle_cycle("5x3");
`ifdef MUL_SIGNED_EN
        run_op(4'd10, 4'd2, 8'hF4, "m6x2", 1'b0);
        idle_cycle("m6x2");
        run_op(4'd15, 4'd15, 8'h01, "m1xm1", 1'b0);
        idle_cycle("m1xm1");
        run_op(4'b1101, 4'b0101, 8'hF1, "m3x5", 1'b0);
        idle_cycle("m3x5");
        run_op(4'b1000, 4'b1000, 8'h40, "m8xm8", 1'b0);
        idle_cycle("m8xm8");
`else
        run_op(4'd10, 4'd2, 8'd20, "10x2", 1'b0);
        idle_cycle("10x2");
        run_op(4'd15, 4'd15, 8'd225, "15x15", 1'b0);
        idle_cycle("15x15");
`endif
        run_op(4'd2, 4'd0, 8'd0, "2x0", 1'b0);
        idle_cycle("2x0");
        run_op(4'd0, 4'd7, 8'd0, "0x7", 1'b0);
        idle_cycle("0x7");

        // Held start with scrambled operands, then back-to-back accept in DONE.
        run_op(4'd5, 4'd3, 8'd15, "b2b_first", 1'b1);
        run_op(4'd6, 4'd7, 8'd42, "b2b_second", 1'b0);
        idle_cycle("b2b");

        // Reset in the second BUSY cycle discards the operation.
        @(negedge clk);
        start = 1'b1;
        A = 4'd9;
        B = 4'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) idle_cycle("after_rst");
        run_op(4'd3, 4'd4, 8'd12, "3x4", 1'b0);
        idle_cycle("3x4");

        // Randomized operations checked against the integer reference.
        for (int n = 0; n < 40; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            run_op(ra, rb, ref_mul(ra, rb), "rand", 1'($urandom));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) idle_cycle("rand");
        end
        idle_cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
